button_event: RTL and testbench

BUTTON_EVENT -- requirements
Module: button_event

---
 rtl/button_event_pkg.sv | 14 +
 rtl/button_event_chan.sv | 101 ++++++++++
 rtl/button_event.sv | 38 +++
 tb/tb_button_event.sv | 115 +++++++++++
 4 files changed

// File: rtl/button_event_pkg.sv
// button_event_pkg: shared channel FSM state encodings and counter sizing helper.
package button_event_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    function automatic int cnt_width(input int a, input int b);
        return $clog2(a > b ? a : b);
    endfunction

endpackage

// File: rtl/button_event_chan.sv
// button_event_chan: one channel's press/release/long/repeat FSM with its hold counter.
module button_event_chan
    import button_event_pkg::*;
#(
    parameter int p_LONG_CLOCKS   = 2**24,
    parameter int p_REPEAT_CLOCKS = 2**22
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat,
    output logic o_held
);

    localparam int c_CNT_W = cnt_width(p_LONG_CLOCKS, p_REPEAT_CLOCKS);
    localparam logic [c_CNT_W-1:0] c_LONG_TC = c_CNT_W'(p_LONG_CLOCKS - 1);
    localparam logic [c_CNT_W-1:0] c_REP_TC  = c_CNT_W'(p_REPEAT_CLOCKS - 1);

    state_t               r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic                 r_press, r_release, r_long, r_repeat, r_held;
    logic                 w_press, w_release, w_long, w_repeat;

    // Release is tested before the terminal counts so it wins a same-edge tie.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_sig) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                    w_press     = 1'b1;
                end
            end
            PRESSED: begin
                if (!i_sig) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_release   = 1'b1;
                end else if (r_cnt == c_LONG_TC) begin
                    w_state_nxt = LONG;
                    w_cnt_nxt   = '0;
                    w_long      = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            LONG: begin
                if (!i_sig) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_release   = 1'b1;
                end else if (r_cnt == c_REP_TC) begin
                    w_cnt_nxt   = '0;
                    w_repeat    = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press;
            r_release <= w_release;
            r_long    <= w_long;
            r_repeat  <= w_repeat;
            r_held    <= (w_state_nxt != IDLE);
        end
    end

    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;
    assign o_repeat  = r_repeat;
    assign o_held    = r_held;

endmodule

// File: rtl/button_event.sv
// button_event: p_PORT_WIDTH independent button event channels.
module button_event
    import button_event_pkg::*;
#(
    parameter int p_PORT_WIDTH    = 4,
    parameter int p_LONG_CLOCKS   = 2**24,
    parameter int p_REPEAT_CLOCKS = 2**22
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [p_PORT_WIDTH-1:0] in_sig,
    output logic [p_PORT_WIDTH-1:0] on_press,
    output logic [p_PORT_WIDTH-1:0] on_release,
    output logic [p_PORT_WIDTH-1:0] on_long,
    output logic [p_PORT_WIDTH-1:0] on_repeat,
    output logic [p_PORT_WIDTH-1:0] on_held
);

    genvar i;
    generate
        for (i = 0; i < p_PORT_WIDTH; i++) begin : g_chan
            button_event_chan #(
                .p_LONG_CLOCKS   (p_LONG_CLOCKS),
                .p_REPEAT_CLOCKS (p_REPEAT_CLOCKS)
            ) u_chan (
                .i_clk     (i_clk),
                .i_rst     (i_rst),
                .i_sig     (in_sig[i]),
                .o_press   (on_press[i]),
                .o_release (on_release[i]),
                .o_long    (on_long[i]),
                .o_repeat  (on_repeat[i]),
                .o_held    (on_held[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_button_event.sv
// tb_button_event: directed vector table plus multi-cycle hold/reset sequences.
module tb_button_event;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] in_sig = 2'b00;
    logic [1:0] on_press, on_release, on_long, on_repeat, on_held;
    int         n_chk = 0;
    int         n_fail = 0;

    typedef struct packed {
        logic [1:0] in;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] lng;
        logic [1:0] rep;
        logic [1:0] held;
    } vec_t;

    vec_t tbl [9];

    button_event #(
        .p_PORT_WIDTH    (2),
        .p_LONG_CLOCKS   (8),
        .p_REPEAT_CLOCKS (4)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .in_sig     (in_sig),
        .on_press   (on_press),
        .on_release (on_release),
        .on_long    (on_long),
        .on_repeat  (on_repeat),
        .on_held    (on_held)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [1:0] in, input logic r);
        in_sig = in;
        rst    = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int k, input logic [1:0] p, input logic [1:0] rl,
                       input logic [1:0] l, input logic [1:0] rp, input logic [1:0] h);
        logic [9:0] act, exp;
        act = {on_press, on_release, on_long, on_repeat, on_held};
        exp = {p, rl, l, rp, h};
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got press/rel/long/rep/held=%b required %b", name, k, act, exp);
        end
    endtask

    initial begin
        // in, press, rel, long, rep, held
        tbl[0] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
        tbl[1] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        tbl[2] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        tbl[3] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        tbl[4] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[5] = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11};
        tbl[6] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
        tbl[7] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
        tbl[8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

        for (int k = 0; k < 3; k++) begin
            step(2'b11, 1'b1);
            chk("reset", k, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        end
        step(2'b00, 1'b0);
        chk("idle_after_reset", 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        for (int k = 0; k < 9; k++) begin
            step(tbl[k].in, 1'b0);
            chk("table", k, tbl[k].press, tbl[k].rel, tbl[k].lng, tbl[k].rep, tbl[k].held);
        end

        for (int k = 0; k < 22; k++) begin
            step(k < 20 ? 2'b01 : 2'b00, 1'b0);
            chk("long_hold", k, {1'b0, k == 0}, {1'b0, k == 20}, {1'b0, k == 8},
                {1'b0, k == 12 || k == 16}, {1'b0, k < 20});
        end

        for (int k = 0; k < 10; k++) begin
            step(k < 8 ? 2'b10 : 2'b00, 1'b0);
            chk("release_at_terminal", k, {k == 0, 1'b0}, {k == 8, 1'b0}, 2'b00, 2'b00, {k < 8, 1'b0});
        end

        for (int k = 0; k < 5; k++) begin
            step(2'b01, 1'b0);
            chk("rst_pre", k, {1'b0, k == 0}, 2'b00, 2'b00, 2'b00, 2'b01);
        end
        step(2'b01, 1'b1);
        chk("rst_mid", 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        step(2'b01, 1'b0);
        chk("rst_repress", 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
        step(2'b00, 1'b0);
        chk("rst_release", 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        step(2'b00, 1'b0);

        for (int k = 0; k < 13; k++) begin
            step(k >= 11 ? 2'b00 : (k >= 2 ? 2'b11 : 2'b01), 1'b0);
            chk("independence", k, {k == 2, k == 0}, {k == 11, k == 11}, {k == 10, k == 8}, 2'b00,
                {k >= 2 && k < 11, k < 11});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
